// File: rtl/apb2axi_issue_sched.sv
// rtl/apb2axi_issue_sched.sv - issue scheduler from gateway directory to write/read request FIFOs
// Pops one directory entry at a time, gated by per-direction credits and an in-flight tag bitmap.
module apb2axi_issue_sched #(
    parameter int FIFO_ENTRY_W = 32,
    parameter int TAG_W        = 4,
    parameter int IS_WRITE_BIT = 0,
    parameter int MAX_WR_OUTST = 4,
    parameter int MAX_RD_OUTST = 4,
    parameter int CNT_W        = $clog2(((MAX_WR_OUTST > MAX_RD_OUTST) ? MAX_WR_OUTST : MAX_RD_OUTST) + 1)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    pending_valid,
    input  logic [FIFO_ENTRY_W-1:0] pending_entry,
    input  logic [TAG_W-1:0]        pending_tag,
    output logic                    pending_pop,
    output logic                    wr_push_valid,
    input  logic                    wr_push_ready,
    output logic [FIFO_ENTRY_W-1:0] wr_push_data,
    output logic                    rd_push_valid,
    input  logic                    rd_push_ready,
    output logic [FIFO_ENTRY_W-1:0] rd_push_data,
    input  logic                    wr_cpl_valid,
    input  logic [TAG_W-1:0]        wr_cpl_tag,
    input  logic                    rd_cpl_valid,
    input  logic [TAG_W-1:0]        rd_cpl_tag,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [CNT_W-1:0]        wr_outst_cnt,
    output logic [CNT_W-1:0]        rd_outst_cnt,
    output logic [(1<<TAG_W)-1:0]   tag_busy,
    output logic                    spurious_cpl
);

    localparam int NTAGS = 1 << TAG_W;
    localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WR_OUTST);
    localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(MAX_RD_OUTST);

    typedef enum logic {IDLE, PUSH} state_t;

    state_t                  state_q, state_d;
    logic [FIFO_ENTRY_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    wr_vld_q, wr_vld_d;
    logic                    rd_vld_q, rd_vld_d;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [NTAGS-1:0]        busy_q, busy_d;
    logic                    spur_q, spur_d;

    logic is_wr, credit_ok, accept;
    logic wr_hs, rd_hs, push_hs;
    logic wr_cpl_ok, rd_cpl_ok;

    assign is_wr     = pending_entry[IS_WRITE_BIT];
    assign credit_ok = is_wr ? (wr_cnt_q < WR_MAX) : (rd_cnt_q < RD_MAX);
    assign accept    = (state_q == IDLE) && pending_valid && !drain_req
                       && !busy_q[pending_tag] && credit_ok;

    assign wr_hs   = wr_vld_q && wr_push_ready;
    assign rd_hs   = rd_vld_q && rd_push_ready;
    assign push_hs = wr_hs || rd_hs;

    // A zero count guard keeps a stray completion from underflowing the counter;
    // equal tags on both sides retire through the write side only.
    assign wr_cpl_ok = wr_cpl_valid && busy_q[wr_cpl_tag] && (wr_cnt_q != '0);
    assign rd_cpl_ok = rd_cpl_valid && busy_q[rd_cpl_tag] && (rd_cnt_q != '0)
                       && !(wr_cpl_valid && (wr_cpl_tag == rd_cpl_tag));

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        tag_d    = tag_q;
        wr_vld_d = wr_vld_q;
        rd_vld_d = rd_vld_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = PUSH;
                    data_d   = pending_entry;
                    tag_d    = pending_tag;
                    wr_vld_d = is_wr;
                    rd_vld_d = !is_wr;
                end
            end
            PUSH: begin
                if (push_hs) begin
                    state_d  = IDLE;
                    wr_vld_d = 1'b0;
                    rd_vld_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                wr_vld_d = 1'b0;
                rd_vld_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy_d   = busy_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        spur_d   = spur_q || (wr_cpl_valid && !wr_cpl_ok) || (rd_cpl_valid && !rd_cpl_ok);
        if (wr_cpl_ok) begin
            busy_d[wr_cpl_tag] = 1'b0;
        end
        if (rd_cpl_ok) begin
            busy_d[rd_cpl_tag] = 1'b0;
        end
        // The issued tag was free at accept and stays free during PUSH, so it never collides with a clear.
        if (push_hs) begin
            busy_d[tag_q] = 1'b1;
        end
        if (wr_hs && !wr_cpl_ok) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (!wr_hs && wr_cpl_ok) begin
            wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end
        if (rd_hs && !rd_cpl_ok) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (!rd_hs && rd_cpl_ok) begin
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            tag_q    <= '0;
            wr_vld_q <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            busy_q   <= '0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            wr_vld_q <= wr_vld_d;
            rd_vld_q <= rd_vld_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            busy_q   <= busy_d;
            spur_q   <= spur_d;
        end
    end

    assign pending_pop   = accept;
    assign wr_push_valid = wr_vld_q;
    assign rd_push_valid = rd_vld_q;
    assign wr_push_data  = data_q;
    assign rd_push_data  = data_q;
    assign wr_outst_cnt  = wr_cnt_q;
    assign rd_outst_cnt  = rd_cnt_q;
    assign tag_busy      = busy_q;
    assign spurious_cpl  = spur_q;
    assign drain_done    = (state_q == IDLE) && (wr_cnt_q == '0) && (rd_cnt_q == '0);

endmodule

// File: tb/tb_apb2axi_issue_sched.sv
// tb/tb_apb2axi_issue_sched.sv - self-checking bench for apb2axi_issue_sched
module tb_apb2axi_issue_sched;

    localparam int EW    = 16;
    localparam int TW    = 4;
    localparam int CNT_W = 3;
    localparam int MAXW  = 4;
    localparam int MAXR  = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            pending_valid;
    logic [EW-1:0]   pending_entry;
    logic [TW-1:0]   pending_tag;
    logic            pending_pop;
    logic            wr_push_valid, wr_push_ready;
    logic [EW-1:0]   wr_push_data;
    logic            rd_push_valid, rd_push_ready;
    logic [EW-1:0]   rd_push_data;
    logic            wr_cpl_valid, rd_cpl_valid;
    logic [TW-1:0]   wr_cpl_tag, rd_cpl_tag;
    logic            drain_req, drain_done;
    logic [CNT_W-1:0] wr_outst_cnt, rd_outst_cnt;
    logic [15:0]     tag_busy;
    logic            spurious_cpl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    apb2axi_issue_sched #(
        .FIFO_ENTRY_W(EW), .TAG_W(TW), .IS_WRITE_BIT(0),
        .MAX_WR_OUTST(MAXW), .MAX_RD_OUTST(MAXR)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .pending_valid(pending_valid), .pending_entry(pending_entry), .pending_tag(pending_tag),
        .pending_pop(pending_pop),
        .wr_push_valid(wr_push_valid), .wr_push_ready(wr_push_ready), .wr_push_data(wr_push_data),
        .rd_push_valid(rd_push_valid), .rd_push_ready(rd_push_ready), .rd_push_data(rd_push_data),
        .wr_cpl_valid(wr_cpl_valid), .wr_cpl_tag(wr_cpl_tag),
        .rd_cpl_valid(rd_cpl_valid), .rd_cpl_tag(rd_cpl_tag),
        .drain_req(drain_req), .drain_done(drain_done),
        .wr_outst_cnt(wr_outst_cnt), .rd_outst_cnt(rd_outst_cnt),
        .tag_busy(tag_busy), .spurious_cpl(spurious_cpl)
    );

    typedef struct {
        logic pv; logic [15:0] ent; logic [3:0] ptag; logic drn; logic wrdy; logic rrdy;
        logic wcv; logic [3:0] wct; logic rcv; logic [3:0] rct;
        logic pop; logic wv; logic rv; logic [15:0] data; logic [2:0] wcnt; logic [2:0] rcnt;
        logic [15:0] busy; logic dd; logic sp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        pending_valid = 0; pending_entry = '0; pending_tag = '0; drain_req = 0;
        wr_push_ready = 0; rd_push_ready = 0;
        wr_cpl_valid = 0; wr_cpl_tag = '0; rd_cpl_valid = 0; rd_cpl_tag = '0;
    endtask

    task automatic do_reset();
        aresetn = 0;
        idle_inputs();
        tick(); tick();
        aresetn = 1;
    endtask

    // Leaves the caller at the negedge of the cycle where pending_pop is high.
    task automatic wait_pop(input string name, input int max_cyc);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge aclk);
            if (pending_pop) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic issue_one(input logic [15:0] ent, input logic [3:0] tag);
        pending_valid = 1; pending_entry = ent; pending_tag = tag;
        wait_pop("issue_pop", 10);
        tick();
        pending_valid = 0;
        tick();
    endtask

    // Reference model: per-tag direction of the transaction in flight (0 none, 1 write, 2 read).
    int          infl[16];
    bit          m_held, m_held_wr, m_sp;
    logic [15:0] m_held_ent;
    logic [3:0]  m_held_tag;

    task automatic model_reset();
        foreach (infl[i]) infl[i] = 0;
        m_held = 0; m_held_wr = 0; m_sp = 0; m_held_ent = '0; m_held_tag = '0;
    endtask

    task automatic random_cycle();
        int nw, nr, cand[$];
        logic [15:0] e_busy;
        bit e_pop, e_wv, e_rv, e_dd, rd_ok;
        pending_valid = ($urandom_range(0, 3) != 0);
        pending_entry = 16'($urandom);
        pending_tag   = 4'($urandom);
        drain_req     = ($urandom_range(0, 15) == 0);
        wr_push_ready = ($urandom_range(0, 2) != 0);
        rd_push_ready = ($urandom_range(0, 2) != 0);
        for (int d = 1; d <= 2; d++) begin
            bit v;
            logic [3:0] t;
            cand.delete();
            foreach (infl[i]) if (infl[i] == d) cand.push_back(i);
            v = 0; t = '0;
            if (cand.size() > 0 && $urandom_range(0, 3) == 0) begin
                v = 1; t = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 149) == 0) begin
                t = 4'($urandom);
                v = (infl[t] == 0);
            end
            if (d == 1) begin wr_cpl_valid = v; wr_cpl_tag = t; end
            else        begin rd_cpl_valid = v; rd_cpl_tag = t; end
        end
        nw = 0; nr = 0; e_busy = '0;
        foreach (infl[i]) begin
            if (infl[i] == 1) nw++;
            if (infl[i] == 2) nr++;
            if (infl[i] != 0) e_busy[i] = 1'b1;
        end
        e_pop = !m_held && pending_valid && !drain_req && infl[pending_tag] == 0
                && (pending_entry[0] ? nw < MAXW : nr < MAXR);
        e_wv = m_held && m_held_wr;
        e_rv = m_held && !m_held_wr;
        e_dd = !m_held && nw == 0 && nr == 0;
        @(negedge aclk);
        chk("rnd_pop", pending_pop, e_pop);
        chk("rnd_wv", wr_push_valid, e_wv);
        chk("rnd_rv", rd_push_valid, e_rv);
        if (e_wv) chk("rnd_wdata", wr_push_data, m_held_ent);
        if (e_rv) chk("rnd_rdata", rd_push_data, m_held_ent);
        chk("rnd_wcnt", wr_outst_cnt, nw);
        chk("rnd_rcnt", rd_outst_cnt, nr);
        chk("rnd_busy", tag_busy, e_busy);
        chk("rnd_dd", drain_done, e_dd);
        chk("rnd_sp", spurious_cpl, m_sp);
        tick();
        rd_ok = rd_cpl_valid && infl[rd_cpl_tag] != 0
                && !(wr_cpl_valid && wr_cpl_tag == rd_cpl_tag);
        if (wr_cpl_valid && infl[wr_cpl_tag] == 0) m_sp = 1;
        if (rd_cpl_valid && !rd_ok) m_sp = 1;
        if (wr_cpl_valid && infl[wr_cpl_tag] != 0) infl[wr_cpl_tag] = 0;
        if (rd_ok) infl[rd_cpl_tag] = 0;
        if (m_held && (m_held_wr ? wr_push_ready : rd_push_ready)) begin
            infl[m_held_tag] = m_held_wr ? 1 : 2;
            m_held = 0;
        end else if (e_pop) begin
            m_held = 1; m_held_wr = pending_entry[0];
            m_held_ent = pending_entry; m_held_tag = pending_tag;
        end
    endtask

    localparam logic [15:0] W = 16'hA5A1;
    localparam logic [15:0] R = 16'h1230;

    initial begin
        do_reset();

        // pv ent ptag drn wrdy rrdy wcv wct rcv rct | pop wv rv data wcnt rcnt busy dd sp
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,1,0});
        tbl.push_back(vec_t'{1,W,3,0,1,0,0,0,0,0, 1,0,0,0,0,0,16'h0000,1,0});
        tbl.push_back(vec_t'{0,0,0,0,1,0,0,0,0,0, 0,1,0,W,0,0,16'h0000,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,16'h0008,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,1,3,0,0, 0,0,0,0,1,0,16'h0008,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,1,0});
        tbl.push_back(vec_t'{1,W,5,0,1,0,0,0,0,0, 1,0,0,0,0,0,16'h0000,1,0});
        tbl.push_back(vec_t'{1,R,5,0,1,0,0,0,0,0, 0,1,0,W,0,0,16'h0000,0,0});
        tbl.push_back(vec_t'{1,R,5,0,0,0,0,0,0,0, 0,0,0,0,1,0,16'h0020,0,0});
        tbl.push_back(vec_t'{1,R,5,0,0,0,1,5,0,0, 0,0,0,0,1,0,16'h0020,0,0});
        tbl.push_back(vec_t'{1,R,5,0,0,1,0,0,0,0, 1,0,0,0,0,0,16'h0000,1,0});
        tbl.push_back(vec_t'{0,0,0,0,0,1,0,0,0,0, 0,0,1,R,0,0,16'h0000,0,0});
        tbl.push_back(vec_t'{1,W,6,0,0,0,0,0,0,0, 1,0,0,0,0,1,16'h0020,0,0});
        tbl.push_back(vec_t'{0,0,0,0,1,0,0,0,1,5, 0,1,0,W,0,1,16'h0020,0,0});
        tbl.push_back(vec_t'{1,W,7,0,0,0,0,0,0,0, 1,0,0,0,1,0,16'h0040,0,0});
        tbl.push_back(vec_t'{0,0,0,0,1,0,1,6,0,0, 0,1,0,W,1,0,16'h0040,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,16'h0080,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,1,7,1,7, 0,0,0,0,1,0,16'h0080,0,0});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,1,1});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,1,2, 0,0,0,0,0,0,16'h0000,1,1});
        tbl.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,16'h0000,1,1});

        foreach (tbl[i]) begin
            pending_valid = tbl[i].pv; pending_entry = tbl[i].ent; pending_tag = tbl[i].ptag;
            drain_req = tbl[i].drn; wr_push_ready = tbl[i].wrdy; rd_push_ready = tbl[i].rrdy;
            wr_cpl_valid = tbl[i].wcv; wr_cpl_tag = tbl[i].wct;
            rd_cpl_valid = tbl[i].rcv; rd_cpl_tag = tbl[i].rct;
            @(negedge aclk);
            chk($sformatf("vec%0d_pop", i), pending_pop, tbl[i].pop);
            chk($sformatf("vec%0d_wv", i), wr_push_valid, tbl[i].wv);
            chk($sformatf("vec%0d_rv", i), rd_push_valid, tbl[i].rv);
            if (tbl[i].wv) chk($sformatf("vec%0d_wdata", i), wr_push_data, tbl[i].data);
            if (tbl[i].rv) chk($sformatf("vec%0d_rdata", i), rd_push_data, tbl[i].data);
            chk($sformatf("vec%0d_wcnt", i), wr_outst_cnt, tbl[i].wcnt);
            chk($sformatf("vec%0d_rcnt", i), rd_outst_cnt, tbl[i].rcnt);
            chk($sformatf("vec%0d_busy", i), tag_busy, tbl[i].busy);
            chk($sformatf("vec%0d_dd", i), drain_done, tbl[i].dd);
            chk($sformatf("vec%0d_sp", i), spurious_cpl, tbl[i].sp);
            tick();
        end

        // Credit limit on the read side.
        do_reset();
        rd_push_ready = 1;
        for (int k = 0; k < 4; k++) issue_one(16'h1000 + 16'(k * 16), 4'(k));
        pending_valid = 1; pending_entry = 16'h1040; pending_tag = 4;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            chk("credit_block_pop", pending_pop, 0);
            tick();
        end
        chk("credit_rcnt_max", rd_outst_cnt, 4);
        chk("credit_busy", tag_busy, 16'h000F);
        rd_cpl_valid = 1; rd_cpl_tag = 1;
        @(negedge aclk);
        chk("credit_cpl_cycle_pop", pending_pop, 0);
        tick();
        rd_cpl_valid = 0;
        @(negedge aclk);
        chk("credit_release_pop", pending_pop, 1);
        tick();
        pending_valid = 0;
        tick();
        @(negedge aclk);
        chk("credit_rcnt_after", rd_outst_cnt, 4);
        chk("credit_busy_after", tag_busy, 16'h001D);

        // Backpressure on the write FIFO.
        do_reset();
        pending_valid = 1; pending_entry = 16'hBEE1; pending_tag = 2;
        wait_pop("bp_first_pop", 10);
        tick();
        pending_entry = 16'hC0D1; pending_tag = 9;
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            chk("bp_wv_held", wr_push_valid, 1);
            chk("bp_data_stable", wr_push_data, 16'hBEE1);
            chk("bp_no_pop", pending_pop, 0);
            tick();
        end
        wr_push_ready = 1;
        tick();
        @(negedge aclk);
        chk("bp_wcnt", wr_outst_cnt, 1);
        chk("bp_busy", tag_busy, 16'h0004);
        chk("bp_next_pop", pending_pop, 1);
        tick();
        pending_valid = 0;
        tick();

        // Drain, then reset mid-PUSH.
        do_reset();
        wr_push_ready = 1;
        issue_one(16'h0011, 1);
        issue_one(16'h0021, 2);
        drain_req = 1;
        pending_valid = 1; pending_entry = 16'h0031; pending_tag = 3;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            chk("drain_no_pop", pending_pop, 0);
            chk("drain_not_done", drain_done, 0);
            tick();
        end
        wr_cpl_valid = 1; wr_cpl_tag = 1;
        tick();
        wr_cpl_tag = 2;
        tick();
        wr_cpl_valid = 0;
        @(negedge aclk);
        chk("drain_done", drain_done, 1);
        chk("drain_still_no_pop", pending_pop, 0);
        tick();
        drain_req = 0; wr_push_ready = 0;
        @(negedge aclk);
        chk("undrain_pop", pending_pop, 1);
        tick();
        pending_valid = 0;
        @(negedge aclk);
        chk("pre_reset_wv", wr_push_valid, 1);
        aresetn = 0;
        tick();
        @(negedge aclk);
        chk("rst_wv", wr_push_valid, 0);
        chk("rst_rv", rd_push_valid, 0);
        chk("rst_wcnt", wr_outst_cnt, 0);
        chk("rst_rcnt", rd_outst_cnt, 0);
        chk("rst_busy", tag_busy, 0);
        chk("rst_sp", spurious_cpl, 0);
        aresetn = 1;

        // Randomized segments against the reference model.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            model_reset();
            for (int c = 0; c < 600; c++) random_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
